// File: rtl/codec_init_sequencer.sv
// SSM2603 power-up sequencer: issues a fixed register table through the I2C
// controller with ack checking and retries, then passes software requests through.
module codec_init_sequencer #(
    parameter int unsigned MAX_RETRIES   = 3,
    parameter logic [31:0] SETTLE_CYCLES = 32'd1_000_000,
    parameter int unsigned BUSY_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       codec_wr_en,
    output logic       codec_rd_en,
    output logic [7:0] codec_reg_addr,
    output logic [8:0] codec_data_in,
    input  logic       controller_busy,
    input  logic       missed_ack,
    input  logic       sw_wr_en,
    input  logic       sw_rd_en,
    input  logic [7:0] sw_addr,
    input  logic [8:0] sw_data,
    output logic       sw_busy,
    output logic       init_done,
    output logic       init_error,
    output logic [3:0] err_index
);

    localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRIES);
    localparam logic [15:0] TMO_LAST    = 16'(BUSY_TIMEOUT - 1);
    localparam logic [31:0] SETTLE_LAST = SETTLE_CYCLES - 32'd1;
    localparam logic [3:0]  IDX_SETTLE  = 4'd9;
    localparam logic [3:0]  IDX_RESUME  = 4'd10;
    localparam logic [3:0]  IDX_LAST    = 4'd11;

    typedef enum logic [2:0] {
        S_RESET_WAIT,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_CHECK,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [8:0] data;
    } entry_t;

    function automatic entry_t table_entry(input logic [3:0] idx);
        entry_t e;
        case (idx)
            4'd0:    e = '{addr: 8'h0F, data: 9'h000};
            4'd1:    e = '{addr: 8'h06, data: 9'h030};
            4'd2:    e = '{addr: 8'h00, data: 9'h017};
            4'd3:    e = '{addr: 8'h01, data: 9'h017};
            4'd4:    e = '{addr: 8'h02, data: 9'h079};
            4'd5:    e = '{addr: 8'h03, data: 9'h079};
            4'd6:    e = '{addr: 8'h04, data: 9'h010};
            4'd7:    e = '{addr: 8'h05, data: 9'h000};
            4'd8:    e = '{addr: 8'h07, data: 9'h002};
            4'd9:    e = '{addr: 8'h08, data: 9'h000};
            4'd10:   e = '{addr: 8'h09, data: 9'h001};
            4'd11:   e = '{addr: 8'h06, data: 9'h020};
            default: e = '{addr: 8'h00, data: 9'h000};
        endcase
        return e;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] settle_q, settle_d;
    logic        fail_q, fail_d;
    logic        pend_q, pend_d;
    logic        pend_rd_q, pend_rd_d;
    logic [7:0]  pend_addr_q, pend_addr_d;
    logic [8:0]  pend_data_q, pend_data_d;
    logic        codec_wr_en_q, codec_wr_en_d;
    logic        codec_rd_en_q, codec_rd_en_d;
    logic [7:0]  codec_reg_addr_q, codec_reg_addr_d;
    logic [8:0]  codec_data_in_q, codec_data_in_d;
    logic        sw_busy_q, sw_busy_d;
    logic        init_done_q, init_done_d;
    logic        init_error_q, init_error_d;
    logic [3:0]  err_index_q, err_index_d;
    entry_t      issue_entry;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path infers a latch.
        state_d          = state_q;
        idx_d            = idx_q;
        retry_d          = retry_q;
        tmo_d            = tmo_q;
        settle_d         = settle_q;
        fail_d           = fail_q;
        pend_d           = pend_q;
        pend_rd_d        = pend_rd_q;
        pend_addr_d      = pend_addr_q;
        pend_data_d      = pend_data_q;
        codec_wr_en_d    = 1'b0;
        codec_rd_en_d    = 1'b0;
        codec_reg_addr_d = codec_reg_addr_q;
        codec_data_in_d  = codec_data_in_q;
        init_done_d      = init_done_q;
        init_error_d     = init_error_q;
        err_index_d      = err_index_q;
        issue_entry      = '0;

        case (state_q)
            S_RESET_WAIT: begin
                if (!controller_busy) begin
                    state_d = S_ISSUE;
                    idx_d   = 4'd0;
                    retry_d = 8'd0;
                end
            end
            S_ISSUE: state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (controller_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    fail_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WAIT_LO: begin
                if (!controller_busy) begin
                    fail_d  = missed_ack;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (fail_q) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_ISSUE;
                    end else begin
                        init_error_d = 1'b1;
                        err_index_d  = idx_q;
                        state_d      = S_ERROR;
                    end
                end else if (idx_q == IDX_SETTLE) begin
                    settle_d = 32'd0;
                    state_d  = S_SETTLE;
                end else if (idx_q == IDX_LAST) begin
                    init_done_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    retry_d = 8'd0;
                    state_d = S_ISSUE;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    idx_d   = IDX_RESUME;
                    retry_d = 8'd0;
                    state_d = S_ISSUE;
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    init_done_d  = 1'b0;
                    init_error_d = 1'b0;
                    err_index_d  = 4'd0;
                    pend_d       = 1'b0;
                    idx_d        = 4'd0;
                    retry_d      = 8'd0;
                    state_d      = S_ISSUE;
                end else if (pend_q) begin
                    // The slot stays occupied through the pulse cycle and frees one cycle later.
                    if (codec_wr_en_q || codec_rd_en_q) begin
                        pend_d = 1'b0;
                    end else if (!controller_busy) begin
                        codec_wr_en_d    = !pend_rd_q;
                        codec_rd_en_d    = pend_rd_q;
                        codec_reg_addr_d = pend_addr_q;
                        codec_data_in_d  = pend_data_q;
                    end
                end else if (sw_wr_en || sw_rd_en) begin
                    pend_d      = 1'b1;
                    pend_rd_d   = !sw_wr_en;
                    pend_addr_d = sw_addr;
                    pend_data_d = sw_data;
                    if (!controller_busy) begin
                        codec_wr_en_d    = sw_wr_en;
                        codec_rd_en_d    = !sw_wr_en;
                        codec_reg_addr_d = sw_addr;
                        codec_data_in_d  = sw_data;
                    end
                end
            end
            default: state_d = S_RESET_WAIT;
        endcase

        // Table writes pulse on the same cycle ISSUE is entered.
        if (state_d == S_ISSUE) begin
            issue_entry      = table_entry(idx_d);
            codec_wr_en_d    = 1'b1;
            codec_reg_addr_d = issue_entry.addr;
            codec_data_in_d  = issue_entry.data;
            tmo_d            = 16'd0;
            fail_d           = 1'b0;
        end

        // Also covers the cycle between a request pulse and the controller raising busy.
        sw_busy_d = !(state_d inside {S_DONE, S_ERROR}) || pend_d || controller_busy
                    || codec_wr_en_d || codec_rd_en_d || codec_wr_en_q || codec_rd_en_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_RESET_WAIT;
            idx_q            <= 4'd0;
            retry_q          <= 8'd0;
            tmo_q            <= 16'd0;
            settle_q         <= 32'd0;
            fail_q           <= 1'b0;
            pend_q           <= 1'b0;
            pend_rd_q        <= 1'b0;
            pend_addr_q      <= 8'd0;
            pend_data_q      <= 9'd0;
            codec_wr_en_q    <= 1'b0;
            codec_rd_en_q    <= 1'b0;
            codec_reg_addr_q <= 8'd0;
            codec_data_in_q  <= 9'd0;
            sw_busy_q        <= 1'b1;
            init_done_q      <= 1'b0;
            init_error_q     <= 1'b0;
            err_index_q      <= 4'd0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            retry_q          <= retry_d;
            tmo_q            <= tmo_d;
            settle_q         <= settle_d;
            fail_q           <= fail_d;
            pend_q           <= pend_d;
            pend_rd_q        <= pend_rd_d;
            pend_addr_q      <= pend_addr_d;
            pend_data_q      <= pend_data_d;
            codec_wr_en_q    <= codec_wr_en_d;
            codec_rd_en_q    <= codec_rd_en_d;
            codec_reg_addr_q <= codec_reg_addr_d;
            codec_data_in_q  <= codec_data_in_d;
            sw_busy_q        <= sw_busy_d;
            init_done_q      <= init_done_d;
            init_error_q     <= init_error_d;
            err_index_q      <= err_index_d;
        end
    end

    assign codec_wr_en    = codec_wr_en_q;
    assign codec_rd_en    = codec_rd_en_q;
    assign codec_reg_addr = codec_reg_addr_q;
    assign codec_data_in  = codec_data_in_q;
    assign sw_busy        = sw_busy_q;
    assign init_done      = init_done_q;
    assign init_error     = init_error_q;
    assign err_index      = err_index_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Scoreboard bench for codec_init_sequencer: a controller model answers requests,
// a monitor pops expected transactions whenever the DUT pulses an enable.
module tb_codec_init_sequencer;

    localparam int SETTLE = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       codec_wr_en, codec_rd_en;
    logic [7:0] codec_reg_addr;
    logic [8:0] codec_data_in;
    logic       controller_busy;
    logic       missed_ack = 1'b0;
    logic       sw_wr_en = 1'b0, sw_rd_en = 1'b0;
    logic [7:0] sw_addr = 8'h00;
    logic [8:0] sw_data = 9'h000;
    logic       sw_busy, init_done, init_error;
    logic [3:0] err_index;

    codec_init_sequencer #(
        .MAX_RETRIES  (3),
        .SETTLE_CYCLES(32'(SETTLE)),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .codec_wr_en    (codec_wr_en),
        .codec_rd_en    (codec_rd_en),
        .codec_reg_addr (codec_reg_addr),
        .codec_data_in  (codec_data_in),
        .controller_busy(controller_busy),
        .missed_ack     (missed_ack),
        .sw_wr_en       (sw_wr_en),
        .sw_rd_en       (sw_rd_en),
        .sw_addr        (sw_addr),
        .sw_data        (sw_data),
        .sw_busy        (sw_busy),
        .init_done      (init_done),
        .init_error     (init_error),
        .err_index      (err_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected register table {addr, data}, written out by hand.
    logic [16:0] tbl [12] = '{
        {8'h0F, 9'h000}, {8'h06, 9'h030}, {8'h00, 9'h017}, {8'h01, 9'h017},
        {8'h02, 9'h079}, {8'h03, 9'h079}, {8'h04, 9'h010}, {8'h05, 9'h000},
        {8'h07, 9'h002}, {8'h08, 9'h000}, {8'h09, 9'h001}, {8'h06, 9'h020}
    };

    // Controller model: 20-cycle busy per request, optional NACK / mute / manual busy.
    logic       mdl_busy = 1'b0;
    logic       mdl_nack = 1'b0;
    int         mdl_cnt = 0;
    int         nack_given = 0;
    int         nack_limit = 0;
    logic [7:0] nack_addr = 8'h00;
    logic       mute = 1'b0, manual = 1'b0, man_busy = 1'b0;
    int         fall_cyc = 0;

    assign controller_busy = manual ? man_busy : mdl_busy;

    always @(negedge clk) begin
        if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                mdl_busy   <= 1'b0;
                missed_ack <= mdl_nack;
                fall_cyc   <= cyc;
            end
        end else if ((codec_wr_en || codec_rd_en) && !mute && !manual) begin
            mdl_nack   <= (codec_reg_addr == nack_addr) && (nack_given < nack_limit);
            if ((codec_reg_addr == nack_addr) && (nack_given < nack_limit))
                nack_given <= nack_given + 1;
            missed_ack <= !((codec_reg_addr == nack_addr) && (nack_given < nack_limit));
            mdl_busy   <= 1'b1;
            mdl_cnt    <= 20;
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [17:0] exp_q[$];
    int          emit_cyc_q[$];
    int          last_emit_cyc = 0;
    logic [17:0] obs;
    logic [17:0] exp_item;
    int          s_cyc, el, fall_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_range(input int a, input int b);
        for (int i = a; i <= b; i++) exp_q.push_back({1'b0, tbl[i]});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_flag(input bit want_err, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_err ? init_error : init_done) break;
        end
    endtask

    task automatic wait_q_size(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == n) break;
            @(negedge clk);
        end
        check("queue_drain", exp_q.size(), n);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (codec_wr_en || codec_rd_en) begin
                    last_emit_cyc = cyc;
                    emit_cyc_q.push_back(cyc);
                    obs = {codec_rd_en, codec_reg_addr, codec_data_in};
                    check("single_enable", codec_wr_en & codec_rd_en, 0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_txn: actual=0x%0h expected=none", obs);
                    end else begin
                        exp_item = exp_q.pop_front();
                        check("txn", obs, exp_item);
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wr_en", codec_wr_en, 0);
        check("rst_rd_en", codec_rd_en, 0);
        check("rst_addr", codec_reg_addr, 0);
        check("rst_data", codec_data_in, 0);
        check("rst_sw_busy", sw_busy, 1);
        check("rst_done", init_done, 0);
        check("rst_error", init_error, 0);
        check("rst_err_index", err_index, 0);

        // Nominal run
        push_range(0, 11);
        emit_cyc_q.delete();
        reset = 1'b0;
        wait_flag(1'b0, 2000);
        check("nom_done", init_done, 1);
        check("nom_error", init_error, 0);
        check("nom_queue", exp_q.size(), 0);
        check("nom_emits", emit_cyc_q.size(), 12);
        if (emit_cyc_q.size() == 12) begin
            check("nom_gap", emit_cyc_q[1] - emit_cyc_q[0], 22);
            check("settle_gap", emit_cyc_q[10] - emit_cyc_q[9], 22 + SETTLE);
        end
        repeat (2) @(negedge clk);
        check("done_sw_idle", sw_busy, 0);

        // Arbitration: request held while busy, second request dropped
        manual = 1'b1;
        man_busy = 1'b1;
        @(negedge clk);
        sw_wr_en = 1'b1; sw_addr = 8'h02; sw_data = 9'h060;
        exp_q.push_back({1'b0, 8'h02, 9'h060});
        @(negedge clk);
        check("pending_sw_busy", sw_busy, 1);
        sw_addr = 8'h07; sw_data = 9'h1FF;
        @(negedge clk);
        sw_wr_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("held_no_wr", codec_wr_en, 0);
            check("held_sw_busy", sw_busy, 1);
        end
        man_busy = 1'b0;
        fall_l = cyc;
        wait_q_size(0, 20);
        check("pending_latency", last_emit_cyc - fall_l, 1);
        repeat (4) @(negedge clk);
        check("arb_idle_sw_busy", sw_busy, 0);

        // Direct read with idle controller
        sw_rd_en = 1'b1; sw_addr = 8'h0F; sw_data = 9'h155;
        s_cyc = cyc;
        exp_q.push_back({1'b1, 8'h0F, 9'h155});
        @(negedge clk);
        sw_rd_en = 1'b0;
        check("direct_sw_busy", sw_busy, 1);
        @(negedge clk);
        check("direct_latency", last_emit_cyc - s_cyc, 1);
        repeat (3) @(negedge clk);

        // Write wins over read
        sw_wr_en = 1'b1; sw_rd_en = 1'b1; sw_addr = 8'h03; sw_data = 9'h0AA;
        exp_q.push_back({1'b0, 8'h03, 9'h0AA});
        @(negedge clk);
        sw_wr_en = 1'b0; sw_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_wins_queue", exp_q.size(), 0);
        manual = 1'b0;
        repeat (2) @(negedge clk);

        // One NACK at idx 4 (R2) -> R2 issued twice
        nack_addr = 8'h02;
        nack_limit = nack_given + 1;
        push_range(0, 4);
        push_range(4, 11);
        pulse_start();
        check("start_clears_done", init_done, 0);
        wait_flag(1'b0, 2000);
        check("nack_done", init_done, 1);
        check("nack_error", init_error, 0);
        check("nack_queue", exp_q.size(), 0);

        // NACK forever at idx 7 (R5) -> 4 attempts then error
        nack_addr = 8'h05;
        nack_limit = 100000;
        push_range(0, 7);
        push_range(7, 7);
        push_range(7, 7);
        push_range(7, 7);
        pulse_start();
        wait_flag(1'b1, 2000);
        check("exh_error", init_error, 1);
        check("exh_err_index", err_index, 7);
        check("exh_done", init_done, 0);
        check("exh_queue", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        nack_limit = nack_given;
        push_range(0, 11);
        pulse_start();
        check("restart_clears_error", init_error, 0);
        check("restart_clears_index", err_index, 0);
        wait_flag(1'b0, 2000);
        check("rerun_done", init_done, 1);
        check("rerun_queue", exp_q.size(), 0);

        // Busy never rises at idx 0 -> 4 timeouts then error
        mute = 1'b1;
        push_range(0, 0);
        push_range(0, 0);
        push_range(0, 0);
        push_range(0, 0);
        pulse_start();
        wait_flag(1'b1, 200);
        el = cyc - s_cyc;
        check("tmo_error", init_error, 1);
        check("tmo_err_index", err_index, 0);
        check("tmo_done", init_done, 0);
        check("tmo_latency_range", (el >= 64 && el <= 80), 1);
        check("tmo_queue", exp_q.size(), 0);
        mute = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during idx 6 while busy -> restart only after busy falls
        push_range(0, 6);
        pulse_start();
        wait_q_size(0, 400);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_en", codec_wr_en, 0);
        check("midrst_addr", codec_reg_addr, 0);
        check("midrst_data", codec_data_in, 0);
        check("midrst_sw_busy", sw_busy, 1);
        check("midrst_error", init_error, 0);
        reset = 1'b0;
        push_range(0, 11);
        wait_q_size(11, 200);
        check("rst_wait_gap", last_emit_cyc - fall_cyc, 1);
        wait_flag(1'b0, 2000);
        check("post_rst_done", init_done, 1);
        check("post_rst_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
